// File: rtl/control_cajero_pkg.sv
// Shared encodings for the cashier sequencing controller and its PIN verifier.
package control_cajero_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PIN          = 3'd1,
      VERIF        = 3'd2,
      ESPERA_TRANS = 3'd3,
      EJECUTA      = 3'd4,
      BLOQUEO      = 3'd5
   } estado_t;

   localparam logic DEPOSITO = 1'b0;
   localparam logic RETIRO   = 1'b1;
   localparam int   MONTO_W  = 32;

endpackage

// File: rtl/control_cajero_verificador_pin.sv
// PIN digit shift buffer, digit counter, comparator and failed-attempt counter.
module verificador_pin #(
   parameter int PIN_DIGITOS  = 4,
   parameter int MAX_INTENTOS = 3,
   parameter int IW           = $clog2(MAX_INTENTOS + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_clr_cuenta,
   input  logic                     i_shift_en,
   input  logic [3:0]               i_digito,
   input  logic [4*PIN_DIGITOS-1:0] i_pin_correcto,
   input  logic                     i_verif,
   input  logic                     i_clr_intentos,
   output logic                     o_completo,
   output logic                     o_coincide,
   output logic [IW-1:0]            o_intentos,
   output logic                     o_advertencia
);

   localparam int CW = $clog2(PIN_DIGITOS + 1);
   localparam int BW = 4 * PIN_DIGITOS;

   logic [BW-1:0] r_buffer;
   logic [CW-1:0] r_cuenta;
   logic [IW-1:0] r_intentos;
   logic          r_advertencia;
   logic [IW-1:0] w_intentos_sig;

   // Completion is flagged on the strobe of the last digit so the compare happens the very next cycle.
   assign o_completo     = i_shift_en && (r_cuenta == CW'(PIN_DIGITOS - 1));
   assign o_coincide     = (r_buffer == i_pin_correcto);
   assign o_intentos     = r_intentos;
   assign o_advertencia  = r_advertencia;
   assign w_intentos_sig = r_intentos + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_buffer <= '0;
         r_cuenta <= '0;
      end else if (i_clr_cuenta) begin
         r_buffer <= '0;
         r_cuenta <= '0;
      end else if (i_shift_en) begin
         r_buffer <= {r_buffer[BW-5:0], i_digito};
         r_cuenta <= r_cuenta + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_intentos    <= '0;
         r_advertencia <= 1'b0;
      end else if (i_clr_intentos) begin
         r_intentos    <= '0;
         r_advertencia <= 1'b0;
      end else if (i_verif) begin
         if (o_coincide) begin
            r_intentos    <= '0;
            r_advertencia <= 1'b0;
         end else begin
            r_intentos    <= w_intentos_sig;
            r_advertencia <= (w_intentos_sig == IW'(MAX_INTENTOS - 1));
         end
      end
   end

endmodule

// File: rtl/control_cajero.sv
// Session sequencer for the automatic cashier: PIN entry, operation latch, transaction launch.
// Optional inactivity abort is built when TIMEOUT_EN is defined.
module control_cajero
   import control_cajero_pkg::*;
#(
   parameter int PIN_DIGITOS    = 4,
   parameter int MAX_INTENTOS   = 3,
   parameter int TIMEOUT_CICLOS = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tarjeta_recibida,
   input  logic                     digito_stb,
   input  logic [3:0]               digito,
   input  logic [4*PIN_DIGITOS-1:0] pin_correcto,
   input  logic                     monto_stb,
   input  logic                     tipo_trans,
   input  logic [MONTO_W-1:0]       monto,
   input  logic                     balance_stb,
   input  logic                     fondos_insuficientes,
   output logic                     trans_inicio,
   output logic                     trans_tipo,
   output logic [MONTO_W-1:0]       trans_monto,
   output logic                     pin_incorrecto,
   output logic                     advertencia,
   output logic                     bloqueo,
   output logic                     sesion_activa,
   output logic                     timeout,
   output logic [2:0]               estado_dbg
);

   localparam int IW = $clog2(MAX_INTENTOS + 1);

   estado_t            r_estado;
   estado_t            w_estado_sig;
   logic               r_trans_inicio;
   logic               r_trans_tipo;
   logic [MONTO_W-1:0] r_trans_monto;
   logic               w_completo;
   logic               w_coincide;
   logic [IW-1:0]      w_intentos;
   logic               w_shift_en;
   logic               w_clr_cuenta;
   logic               w_verif;
   logic               w_clr_intentos;
   logic               w_pin_incorrecto;
   logic               w_lanzar;
   logic               w_timeout;

   assign w_shift_en   = digito_stb && tarjeta_recibida && (r_estado == PIN);
   assign w_clr_cuenta = (r_estado != PIN);

   verificador_pin #(
      .PIN_DIGITOS  (PIN_DIGITOS),
      .MAX_INTENTOS (MAX_INTENTOS),
      .IW           (IW)
   ) u_verificador (
      .clk            (clk),
      .reset          (reset),
      .i_clr_cuenta   (w_clr_cuenta),
      .i_shift_en     (w_shift_en),
      .i_digito       (digito),
      .i_pin_correcto (pin_correcto),
      .i_verif        (w_verif),
      .i_clr_intentos (w_clr_intentos),
      .o_completo     (w_completo),
      .o_coincide     (w_coincide),
      .o_intentos     (w_intentos),
      .o_advertencia  (advertencia)
   );

`ifdef TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CICLOS);

   logic [TW-1:0] r_inactivo;
   logic          w_vigilado;

   assign w_vigilado = (r_estado == PIN) || (r_estado == ESPERA_TRANS);
   assign w_timeout  = w_vigilado && tarjeta_recibida && !digito_stb && !monto_stb &&
                       (r_inactivo == TW'(TIMEOUT_CICLOS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_inactivo <= '0;
      end else if (!w_vigilado || digito_stb || monto_stb || (w_estado_sig != r_estado)) begin
         r_inactivo <= '0;
      end else begin
         r_inactivo <= r_inactivo + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_estado <= IDLE;
      end else begin
         r_estado <= w_estado_sig;
      end
   end

   // Card removal is tested first in every session state so it beats any same-cycle strobe.
   always_comb begin
      w_estado_sig     = r_estado;
      w_verif          = 1'b0;
      w_clr_intentos   = 1'b0;
      w_pin_incorrecto = 1'b0;
      w_lanzar         = 1'b0;
      unique case (r_estado)
         IDLE: begin
            if (tarjeta_recibida) w_estado_sig = PIN;
         end
         PIN: begin
            if (!tarjeta_recibida) begin
               w_estado_sig   = IDLE;
               w_clr_intentos = 1'b1;
            end else if (w_timeout) begin
               w_estado_sig = IDLE;
            end else if (w_completo) begin
               w_estado_sig = VERIF;
            end
         end
         VERIF: begin
            if (!tarjeta_recibida) begin
               w_estado_sig   = IDLE;
               w_clr_intentos = 1'b1;
            end else begin
               w_verif = 1'b1;
               if (w_coincide) begin
                  w_estado_sig = ESPERA_TRANS;
               end else begin
                  w_pin_incorrecto = 1'b1;
                  w_estado_sig = (w_intentos == IW'(MAX_INTENTOS - 1)) ? BLOQUEO : PIN;
               end
            end
         end
         ESPERA_TRANS: begin
            if (!tarjeta_recibida) begin
               w_estado_sig   = IDLE;
               w_clr_intentos = 1'b1;
            end else if (monto_stb) begin
               w_estado_sig = EJECUTA;
               w_lanzar     = 1'b1;
            end else if (w_timeout) begin
               w_estado_sig = IDLE;
            end
         end
         EJECUTA: begin
            if (balance_stb || fondos_insuficientes) begin
               w_estado_sig = tarjeta_recibida ? ESPERA_TRANS : IDLE;
            end
         end
         BLOQUEO: begin
            w_estado_sig = BLOQUEO;
         end
         default: begin
            w_estado_sig = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_trans_inicio <= 1'b0;
         r_trans_tipo   <= DEPOSITO;
         r_trans_monto  <= '0;
      end else begin
         r_trans_inicio <= w_lanzar;
         if (w_lanzar) begin
            r_trans_tipo  <= tipo_trans;
            r_trans_monto <= monto;
         end
      end
   end

   assign trans_inicio   = r_trans_inicio;
   assign trans_tipo     = r_trans_tipo;
   assign trans_monto    = r_trans_monto;
   assign pin_incorrecto = w_pin_incorrecto;
   assign bloqueo        = (r_estado == BLOQUEO);
   assign sesion_activa  = (r_estado == ESPERA_TRANS) || (r_estado == EJECUTA);
   assign timeout        = w_timeout;
   assign estado_dbg     = r_estado;

endmodule

// File: tb/tb_control_cajero.sv
// Directed bench for control_cajero: PIN vector table plus hand-written session sequences.
module tb_control_cajero;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tarjeta_recibida = 1'b0;
   logic        digito_stb = 1'b0;
   logic [3:0]  digito = '0;
   logic [15:0] pin_correcto = '0;
   logic        monto_stb = 1'b0;
   logic        tipo_trans = 1'b0;
   logic [31:0] monto = '0;
   logic        balance_stb = 1'b0;
   logic        fondos_insuficientes = 1'b0;
   logic        trans_inicio;
   logic        trans_tipo;
   logic [31:0] trans_monto;
   logic        pin_incorrecto;
   logic        advertencia;
   logic        bloqueo;
   logic        sesion_activa;
   logic        timeout;
   logic [2:0]  estado_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [2:0] S_IDLE = 3'd0, S_PIN = 3'd1, S_ESPERA = 3'd3,
                          S_EJECUTA = 3'd4, S_BLOQUEO = 3'd5;

   control_cajero #(
      .PIN_DIGITOS    (4),
      .MAX_INTENTOS   (3),
      .TIMEOUT_CICLOS (16)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .tarjeta_recibida     (tarjeta_recibida),
      .digito_stb           (digito_stb),
      .digito               (digito),
      .pin_correcto         (pin_correcto),
      .monto_stb            (monto_stb),
      .tipo_trans           (tipo_trans),
      .monto                (monto),
      .balance_stb          (balance_stb),
      .fondos_insuficientes (fondos_insuficientes),
      .trans_inicio         (trans_inicio),
      .trans_tipo           (trans_tipo),
      .trans_monto          (trans_monto),
      .pin_incorrecto       (pin_incorrecto),
      .advertencia          (advertencia),
      .bloqueo              (bloqueo),
      .sesion_activa        (sesion_activa),
      .timeout              (timeout),
      .estado_dbg           (estado_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tarjeta_recibida = 1'b0;
      digito_stb = 1'b0;
      monto_stb = 1'b0;
      balance_stb = 1'b0;
      fondos_insuficientes = 1'b0;
      tipo_trans = 1'b0;
      monto = '0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic insert();
      tarjeta_recibida = 1'b1;
      tick();
   endtask

   task automatic enter_digit(input logic [3:0] d);
      digito = d;
      digito_stb = 1'b1;
      tick();
      digito_stb = 1'b0;
   endtask

   task automatic enter_pin(input logic [15:0] p);
      for (int i = 3; i >= 0; i--) enter_digit(p[i*4 +: 4]);
   endtask

   task automatic request(input logic t, input logic [31:0] m);
      tipo_trans = t;
      monto = m;
      monto_stb = 1'b1;
      tick();
      monto_stb = 1'b0;
   endtask

   task automatic open_session();
      do_reset();
      pin_correcto = 16'h1234;
      insert();
      enter_pin(16'h1234);
      tick();
   endtask

   typedef struct {
      logic [15:0] pin;
      logic [15:0] entrada;
      logic        exp_inc;
      logic        exp_ses;
      logic [2:0]  exp_est;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int n;
      vecs[0] = '{16'h1234, 16'h1234, 1'b0, 1'b1, S_ESPERA};
      vecs[1] = '{16'h1234, 16'h1235, 1'b1, 1'b0, S_PIN};
      vecs[2] = '{16'h9876, 16'h9876, 1'b0, 1'b1, S_ESPERA};
      vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b1, S_ESPERA};
      vecs[4] = '{16'h9999, 16'h9990, 1'b1, 1'b0, S_PIN};
      vecs[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, S_PIN};
      vecs[6] = '{16'h0909, 16'h0909, 1'b0, 1'b1, S_ESPERA};

      // reset state, checked while reset is held
      reset = 1'b0;
      tick();
      check("rst_estado", 32'(estado_dbg), 32'(S_IDLE));
      check("rst_outputs", {24'd0, trans_inicio, trans_tipo, pin_incorrecto, advertencia,
                            bloqueo, sesion_activa, timeout, 1'b0}, 32'd0);
      check("rst_monto", trans_monto, 32'd0);

      // PIN vector table
      for (int i = 0; i < 7; i++) begin
         do_reset();
         pin_correcto = vecs[i].pin;
         insert();
         check($sformatf("v%0d_pin_state", i), 32'(estado_dbg), 32'(S_PIN));
         enter_pin(vecs[i].entrada);
         check($sformatf("v%0d_incorrecto", i), 32'(pin_incorrecto), 32'(vecs[i].exp_inc));
         check($sformatf("v%0d_ses_early", i), 32'(sesion_activa), 32'd0);
         tick();
         check($sformatf("v%0d_sesion", i), 32'(sesion_activa), 32'(vecs[i].exp_ses));
         check($sformatf("v%0d_estado", i), 32'(estado_dbg), 32'(vecs[i].exp_est));
         check($sformatf("v%0d_inc_pulse", i), 32'(pin_incorrecto), 32'd0);
         check($sformatf("v%0d_adv", i), 32'(advertencia), 32'd0);
      end

      // lockout after three wrong entries; only reset releases it
      do_reset();
      pin_correcto = 16'h1234;
      insert();
      enter_pin(16'h1235);
      check("lk1_inc", 32'(pin_incorrecto), 32'd1);
      tick();
      check("lk1_adv", 32'(advertencia), 32'd0);
      enter_pin(16'h1235);
      check("lk2_inc", 32'(pin_incorrecto), 32'd1);
      tick();
      check("lk2_adv", 32'(advertencia), 32'd1);
      check("lk2_estado", 32'(estado_dbg), 32'(S_PIN));
      enter_pin(16'h1235);
      check("lk3_inc", 32'(pin_incorrecto), 32'd1);
      tick();
      check("lk3_bloqueo", 32'(bloqueo), 32'd1);
      check("lk3_estado", 32'(estado_dbg), 32'(S_BLOQUEO));
      check("lk3_adv", 32'(advertencia), 32'd0);
      check("lk3_ses", 32'(sesion_activa), 32'd0);
      tarjeta_recibida = 1'b0;
      tick();
      tick();
      check("lk_removed", 32'(bloqueo), 32'd1);
      insert();
      enter_pin(16'h1234);
      tick();
      check("lk_ignore_pin", 32'(estado_dbg), 32'(S_BLOQUEO));
      check("lk_ignore_ses", 32'(sesion_activa), 32'd0);
      do_reset();
      check("lk_reset", 32'(bloqueo), 32'd0);
      check("lk_reset_est", 32'(estado_dbg), 32'(S_IDLE));

      // deposit, withdrawal with insufficient funds, simultaneous strobes
      open_session();
      request(1'b0, 32'd100);
      check("tx1_inicio", 32'(trans_inicio), 32'd1);
      check("tx1_monto", trans_monto, 32'd100);
      check("tx1_tipo", 32'(trans_tipo), 32'd0);
      check("tx1_estado", 32'(estado_dbg), 32'(S_EJECUTA));
      tick();
      check("tx1_inicio_once", 32'(trans_inicio), 32'd0);
      check("tx1_wait", 32'(estado_dbg), 32'(S_EJECUTA));
      balance_stb = 1'b1;
      tick();
      balance_stb = 1'b0;
      check("tx1_done", 32'(estado_dbg), 32'(S_ESPERA));
      check("tx1_ses", 32'(sesion_activa), 32'd1);
      request(1'b1, 32'd2000);
      check("tx2_inicio", 32'(trans_inicio), 32'd1);
      check("tx2_monto", trans_monto, 32'd2000);
      check("tx2_tipo", 32'(trans_tipo), 32'd1);
      tick();
      fondos_insuficientes = 1'b1;
      tick();
      fondos_insuficientes = 1'b0;
      check("tx2_done", 32'(estado_dbg), 32'(S_ESPERA));
      check("tx2_ses", 32'(sesion_activa), 32'd1);
      check("tx2_hold", trans_monto, 32'd2000);
      request(1'b0, 32'd7);
      balance_stb = 1'b1;
      fondos_insuficientes = 1'b1;
      tick();
      balance_stb = 1'b0;
      fondos_insuficientes = 1'b0;
      check("tx3_both", 32'(estado_dbg), 32'(S_ESPERA));
      check("tx3_monto", trans_monto, 32'd7);

      // card removal clears attempts and partial digits; removal beats monto_stb
      do_reset();
      pin_correcto = 16'h1234;
      insert();
      enter_pin(16'h1235);
      tick();
      tarjeta_recibida = 1'b0;
      tick();
      check("rm_pin_idle", 32'(estado_dbg), 32'(S_IDLE));
      insert();
      enter_pin(16'h1235);
      tick();
      check("rm_intentos_clr", 32'(advertencia), 32'd0);
      enter_digit(4'd9);
      enter_digit(4'd9);
      tarjeta_recibida = 1'b0;
      tick();
      check("rm_mid_idle", 32'(estado_dbg), 32'(S_IDLE));
      insert();
      enter_pin(16'h1234);
      check("rm_reentry_inc", 32'(pin_incorrecto), 32'd0);
      tick();
      check("rm_reentry_ses", 32'(sesion_activa), 32'd1);
      tarjeta_recibida = 1'b0;
      tipo_trans = 1'b1;
      monto = 32'd55;
      monto_stb = 1'b1;
      tick();
      monto_stb = 1'b0;
      check("rm_wins_est", 32'(estado_dbg), 32'(S_IDLE));
      check("rm_wins_inicio", 32'(trans_inicio), 32'd0);
      check("rm_wins_monto", trans_monto, 32'd0);
      check("rm_wins_ses", 32'(sesion_activa), 32'd0);

      // removal during EJECUTA waits for completion
      open_session();
      request(1'b1, 32'd300);
      tarjeta_recibida = 1'b0;
      tick();
      tick();
      check("ej_hold", 32'(estado_dbg), 32'(S_EJECUTA));
      balance_stb = 1'b1;
      tick();
      balance_stb = 1'b0;
      check("ej_idle", 32'(estado_dbg), 32'(S_IDLE));
      check("ej_ses", 32'(sesion_activa), 32'd0);
      tick();
      check("ej_stay_idle", 32'(estado_dbg), 32'(S_IDLE));

      // asynchronous reset mid-EJECUTA
      open_session();
      request(1'b1, 32'hDEAD);
      check("ar_inicio_pre", 32'(trans_inicio), 32'd1);
      reset = 1'b0;
      #2;
      check("ar_inicio", 32'(trans_inicio), 32'd0);
      check("ar_monto", trans_monto, 32'd0);
      check("ar_tipo", 32'(trans_tipo), 32'd0);
      check("ar_estado", 32'(estado_dbg), 32'(S_IDLE));
      check("ar_ses", 32'(sesion_activa), 32'd0);

      // inactivity in ESPERA_TRANS
      open_session();
`ifdef TIMEOUT_EN
      n = 1;
      while (!timeout && n < 40) begin
         tick();
         n++;
      end
      check("to_cycle", 32'(n), 32'd16);
      tick();
      check("to_idle", 32'(estado_dbg), 32'(S_IDLE));
      check("to_pulse", 32'(timeout), 32'd0);
      check("to_ses", 32'(sesion_activa), 32'd0);
`else
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (timeout) n++;
         tick();
      end
      check("no_timeout", 32'(n), 32'd0);
      check("no_timeout_est", 32'(estado_dbg), 32'(S_ESPERA));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/control_cajero.md
Name: control_cajero

Overview:
Sequencing controller for the automatic cashier. It owns the session from card insertion to card removal and performs these steps:
- collects and verifies a PIN, counting failed attempts and locking after too many;
- latches the requested operation (deposit/withdrawal plus amount);
- launches the transaccion datapath and waits for its completion strobe.
It sits between the keypad/card front end and the transaccion unit.

Parameters:
PIN_DIGITOS, 4, number of BCD digits in the PIN (pin buffer width = 4*PIN_DIGITOS)
MAX_INTENTOS, 3, failed PIN attempts that cause lockout
TIMEOUT_CICLOS, 1024, idle cycles before session abort (used only with TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
tarjeta_recibida  input  1  level, card present
digito_stb  input  1  one-cycle pulse, digito valid
digito  input  4  PIN digit 0-9
pin_correcto  input  4*PIN_DIGITOS  stored PIN of inserted card, stable while card present
monto_stb  input  1  one-cycle pulse, operation request valid
tipo_trans  input  1  0 deposit, 1 withdrawal; sampled on monto_stb
monto  input  32  amount; sampled on monto_stb
balance_stb  input  1  transaccion unit: balance updated (success)
fondos_insuficientes  input  1  transaccion unit: withdrawal rejected
trans_inicio  output  1  one-cycle launch pulse to transaccion unit
trans_tipo  output  1  latched tipo_trans
trans_monto  output  32  latched monto
pin_incorrecto  output  1  one-cycle pulse per failed attempt
advertencia  output  1  level, exactly one attempt remains
bloqueo  output  1  level, card locked
sesion_activa  output  1  level, PIN accepted and card present
timeout  output  1  one-cycle pulse on inactivity abort (tied 0 without TIMEOUT_EN)

Behaviour:
- Reset (reset=0, async):
  - state IDLE;
  - intentos=0, digit count=0, pin buffer=0;
  - all outputs 0, including trans_tipo and trans_monto.
- IDLE: tarjeta_recibida=1 -> PIN next cycle; digit count cleared.
- PIN:
  - each digito_stb shifts digito in at the LSB (first digit ends in the MS nibble) and increments the count;
  - when count reaches PIN_DIGITOS -> VERIF.
- VERIF (exactly 1 cycle; digito_stb is ignored in this state):
  - Match: intentos=0, advertencia=0 -> ESPERA_TRANS; sesion_activa=1 from the next cycle.
  - Mismatch:
    - pin_incorrecto pulses this cycle and intentos increments;
    - if new intentos == MAX_INTENTOS-1, advertencia=1;
    - if new intentos == MAX_INTENTOS -> BLOQUEO, otherwise -> PIN with the count cleared.
- ESPERA_TRANS: on monto_stb, latch tipo_trans into trans_tipo and monto into trans_monto -> EJECUTA.
- EJECUTA:
  - trans_inicio=1 on the first cycle only;
  - then wait for balance_stb or fondos_insuficientes -> ESPERA_TRANS (multiple operations per session);
  - if both strobes arrive in the same cycle, treat as fondos_insuficientes, with the same transition.
- BLOQUEO:
  - bloqueo=1, sesion_activa=0; all inputs ignored;
  - exit only by reset.
- Card removal (tarjeta_recibida=0):
  - in PIN/VERIF/ESPERA_TRANS: -> IDLE next cycle; intentos, advertencia and sesion_activa cleared. Removal wins over a same-cycle monto_stb or digito_stb.
  - in EJECUTA: the transaction completes first, then -> IDLE.
  - in BLOQUEO: no effect.
- Launch latency: trans_inicio asserts 1 cycle after the monto_stb edge.
- Verification latency: pin_incorrecto asserts 1 cycle after the final digit.
- trans_monto holds its value until the next monto_stb or reset.

Optional Feature:
- Macro: TIMEOUT_EN.
- Defined:
  - an inactivity counter increments each cycle in PIN and ESPERA_TRANS;
  - it clears on digito_stb, monto_stb or state change;
  - reaching TIMEOUT_CICLOS-1 pulses timeout and goes to IDLE, clearing the session like card removal;
  - intentos is not reset by a timeout if the card is still present; the next PIN entry continues the count;
  - EJECUTA and BLOQUEO are never timed out.
- Undefined: no counter logic; timeout is constant 0.

Decomposition:
- Shared package/include control_cajero_pkg holds:
  - state encodings IDLE, PIN, VERIF, ESPERA_TRANS, EJECUTA, BLOQUEO (3-bit);
  - DEPOSITO=1'b0, RETIRO=1'b1;
  - monto width 32.
- Sub-module verificador_pin holds:
  - digit shift buffer, digit counter, compare logic and attempts counter;
  - outputs: completo, coincide, intentos, advertencia.
- The FSM, operation latch and timeout counter stay in control_cajero.

Test Plan:
- pin_correcto=16'h1234, card in, digits 1,2,3,4 -> sesion_activa=1 two cycles after the 4th digito_stb; pin_incorrecto never pulses.
- Digits 1,2,3,5 twice -> two pin_incorrecto pulses, advertencia=1 after the 2nd; a third wrong entry -> bloqueo=1. Card removal then changes nothing; only reset clears it.
- Session open, monto_stb with tipo_trans=0 and monto=100 -> trans_inicio one pulse with trans_monto=100 and trans_tipo=0; balance_stb -> back to ESPERA_TRANS. Then tipo_trans=1 with monto=2000, followed by fondos_insuficientes -> ESPERA_TRANS, sesion_activa still 1.
- Card removed mid-PIN after 2 digits -> IDLE next cycle. Reinsert and enter 1,2,3,4 -> accepted; no stale digits from the earlier entry.
- Card removed during EJECUTA -> state held until balance_stb, then IDLE; sesion_activa=0.
- TIMEOUT_EN with TIMEOUT_CICLOS=16: no input in ESPERA_TRANS for 16 cycles -> timeout pulse, IDLE. Reset asserted mid-EJECUTA -> all outputs 0 immediately.
